// File: rtl/event_window_scheduler3.sv
// event_window_scheduler3
//   Event-driven 3x3 window scheduler for a 256x256 frame. Each accepted pixel
//   event is written into an internal frame memory. The centre of every in-frame
//   3x3 window that contains the event is queued in a todo FIFO. Queued windows
//   are later gathered from memory and emitted to a downstream 3x3 kernel.
//
//   Optional feature (compile-time macro EVENT_SCHED3_DEDUP_EN):
//     A 65536-bit pending bitmap suppresses pushing a centre that is already
//     queued. Without the macro every in-frame candidate is pushed, so
//     duplicates can appear.
//
// Ports
//   clk                  in   rising-edge clock
//   rst_n                in   asynchronous active-low reset (frame memory is kept)
//   in_event_value       in   pixel value
//   in_event_addr        in   {row[15:8], col[7:0]}
//   in_event_valid       in   event strobe
//   ready_for_new_event  out  event accepted when valid && ready
//   window_req           in   downstream can take a window (level, sampled in IDLE)
//   out_window_value     out  element k at [k*DW +: DW], k = (dr+1)*3 + (dc+1)
//   out_window_addr      out  window centre {row, col}
//   out_window_valid     out  one-cycle pulse per emitted window
module event_window_scheduler3 #(
  parameter int DATA_WIDTH             = 4,
  parameter int HALF_WINDOW_SIZE       = 1,
  parameter int TODO_WINDOW_FIFO_DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_event_value,
  input  logic [15:0]             in_event_addr,
  input  logic                    in_event_valid,
  output logic                    ready_for_new_event,
  input  logic                    window_req,
  output logic [9*DATA_WIDTH-1:0] out_window_value,
  output logic [15:0]             out_window_addr,
  output logic                    out_window_valid
);

  localparam int WIN_SIDE = 2 * HALF_WINDOW_SIZE + 1;
  localparam int TAPS     = WIN_SIDE * WIN_SIDE;
  localparam int AW       = $clog2(TODO_WINDOW_FIFO_DEPTH);
  localparam int CW       = AW + 1;

  // Room for a whole event's worth of centres must remain before accepting.
  localparam logic [CW-1:0] READY_MAX_COUNT = CW'(TODO_WINDOW_FIFO_DEPTH - TAPS);
  localparam logic [CW-1:0] FULL_COUNT      = CW'(TODO_WINDOW_FIFO_DEPTH);
  localparam logic [3:0]    LAST_TAP        = 4'(TAPS - 1);
  localparam logic [3:0]    GATHER_LAST     = 4'(TAPS);

  typedef enum logic [1:0] {IDLE, WRITE, GATHER, EMIT} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [3:0]                  step;
  logic [15:0]                 cur_addr;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic [15:0]                 fifo_head;
  logic [1:0]                  dr_off;
  logic [1:0]                  dc_off;
  logic [8:0]                  row_sum;
  logic [8:0]                  col_sum;
  logic                        nb_in;
  logic [15:0]                 nb_addr;
  logic                        already_queued;
  logic                        pop;
  logic                        push;
  logic                        accept;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_zero;
  logic [DATA_WIDTH-1:0]       elem;
  logic [(TAPS-1)*DATA_WIDTH-1:0] gather_buf;

  logic [DATA_WIDTH-1:0] frame_mem [0:65535];
  logic [15:0]           fifo_mem  [0:TODO_WINDOW_FIFO_DEPTH-1];

  // Popping a queued window takes priority over accepting a new event.
  assign pop    = (state == IDLE) && window_req && (count != '0);
  assign ready_for_new_event = (state == IDLE) && (count <= READY_MAX_COUNT) &&
                               !(window_req && (count != '0));
  assign accept = in_event_valid && ready_for_new_event;

  // Tap index k (step) split into row/column offsets, stored as offset+1.
  always_comb begin
    dr_off = 2'd0;
    dc_off = 2'd0;
    case (step)
      4'd0: begin dr_off = 2'd0; dc_off = 2'd0; end
      4'd1: begin dr_off = 2'd0; dc_off = 2'd1; end
      4'd2: begin dr_off = 2'd0; dc_off = 2'd2; end
      4'd3: begin dr_off = 2'd1; dc_off = 2'd0; end
      4'd4: begin dr_off = 2'd1; dc_off = 2'd1; end
      4'd5: begin dr_off = 2'd1; dc_off = 2'd2; end
      4'd6: begin dr_off = 2'd2; dc_off = 2'd0; end
      4'd7: begin dr_off = 2'd2; dc_off = 2'd1; end
      4'd8: begin dr_off = 2'd2; dc_off = 2'd2; end
      default: begin dr_off = 2'd0; dc_off = 2'd0; end
    endcase
  end

  // Neighbour coordinate is (sum - 1); the 9-bit sum exposes both the -1
  // underflow (sum == 0) and the 256 overflow (sum == 257) without wrapping.
  assign row_sum = {1'b0, cur_addr[15:8]} + {7'd0, dr_off};
  assign col_sum = {1'b0, cur_addr[7:0]}  + {7'd0, dc_off};
  assign nb_in   = (row_sum != 9'd0) && (row_sum <= 9'd256) &&
                   (col_sum != 9'd0) && (col_sum <= 9'd256);
  assign nb_addr = {row_sum[7:0] - 8'd1, col_sum[7:0] - 8'd1};

  assign push = (state == WRITE) && nb_in && !already_queued && (count != FULL_COUNT);

`ifdef EVENT_SCHED3_DEDUP_EN
  // One bit per frame position marks a centre currently sitting in the FIFO.
  logic [65535:0] pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (push) pending[nb_addr]   <= 1'b1;
      if (pop)  pending[fifo_head] <= 1'b0;
    end
  end

  assign already_queued = pending[nb_addr];
`else
  assign already_queued = 1'b0;
`endif

  // Frame memory has no reset so that pixel history survives rst_n.
  // Reads run every cycle; the out-of-frame flag travels alongside the data.
  always_ff @(posedge clk) begin
    if (accept) frame_mem[in_event_addr] <= in_event_value;
    rd_data <= frame_mem[nb_addr];
    rd_zero <= !nb_in;
  end

  assign elem = rd_zero ? '0 : rd_data;

  // FIFO storage; occupancy and pointers live in the reset block below.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= nb_addr;
  end

  assign fifo_head = fifo_mem[rd_ptr];

  // Next-state logic. GATHER issues TAPS reads and needs one extra cycle for
  // the last read to return, which gives the pop-to-valid latency of 11.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pop)         state_next = GATHER;
        else if (accept) state_next = WRITE;
      end
      WRITE:   if (step == LAST_TAP)    state_next = IDLE;
      GATHER:  if (step == GATHER_LAST) state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, FIFO bookkeeping, gather shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      step             <= '0;
      cur_addr         <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      gather_buf       <= '0;
      out_window_valid <= 1'b0;
      out_window_value <= '0;
      out_window_addr  <= '0;
    end else begin
      state <= state_next;

      if (state_next != state)                   step <= '0;
      else if (state == WRITE || state == GATHER) step <= step + 4'd1;

      if (pop)         cur_addr <= fifo_head;
      else if (accept) cur_addr <= in_event_addr;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Elements arrive in k order; shifting in at the top leaves k0 at the bottom.
      if (state == GATHER && step != 4'd0 && step != GATHER_LAST)
        gather_buf <= {elem, gather_buf[(TAPS-1)*DATA_WIDTH-1:DATA_WIDTH]};

      out_window_valid <= 1'b0;
      if (state == GATHER && step == GATHER_LAST) begin
        out_window_valid <= 1'b1;
        out_window_value <= {elem, gather_buf};
        out_window_addr  <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_event_window_scheduler3.sv
// tb_event_window_scheduler3
//   Self-checking bench for event_window_scheduler3. Table-driven single-event
//   vectors plus hand-written sequences for FIFO fill, reset mid-gather and
//   duplicate events (EVENT_SCHED3_DEDUP_EN selects the expected count).
module tb_event_window_scheduler3;

  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   in_event_value = '0;
  logic [15:0]     in_event_addr = '0;
  logic            in_event_valid = 1'b0;
  logic            window_req = 1'b0;
  logic            ready_for_new_event;
  logic [9*DW-1:0] out_window_value;
  logic [15:0]     out_window_addr;
  logic            out_window_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_window_scheduler3 #(
    .DATA_WIDTH(DW),
    .HALF_WINDOW_SIZE(1),
    .TODO_WINDOW_FIFO_DEPTH(256)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_event_value(in_event_value),
    .in_event_addr(in_event_addr),
    .in_event_valid(in_event_valid),
    .ready_for_new_event(ready_for_new_event),
    .window_req(window_req),
    .out_window_value(out_window_value),
    .out_window_addr(out_window_addr),
    .out_window_valid(out_window_valid)
  );

  typedef struct {
    logic [15:0]     addr;
    logic [9*DW-1:0] value;
  } win_t;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  val;
    int          count;
    logic [15:0] first;
    logic [15:0] last;
    logic [15:0] spot_a;
    int          spot_a_k;
    logic [3:0]  spot_a_val;
    logic [15:0] spot_b;
    int          spot_b_k;
    logic [3:0]  spot_b_val;
  } vec_t;

  win_t          got_q[$];
  logic [15:0]   exp_q[$];
  logic [DW-1:0] model_mem[int];
  bit            pend[int];
  vec_t          vecs[6];

  // Every emitted window is captured mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (out_window_valid) begin
      win_t w;
      w.addr  = out_window_addr;
      w.value = out_window_value;
      got_q.push_back(w);
    end
  end

  function automatic logic [DW-1:0] modelRead(int r, int c);
    if (r < 0 || r > 255 || c < 0 || c > 255) return '0;
    if (model_mem.exists(r * 256 + c)) return model_mem[r * 256 + c];
    return '0;
  endfunction

  function automatic logic [9*DW-1:0] modelWindow(logic [15:0] centre);
    logic [9*DW-1:0] w;
    int r;
    int c;
    w = '0;
    r = int'(centre[15:8]);
    c = int'(centre[7:0]);
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = modelRead(r + k / 3 - 1, c + k % 3 - 1);
    return w;
  endfunction

  function automatic void modelEvent(logic [15:0] addr, logic [DW-1:0] val);
    int r;
    int c;
    int cen;
    r = int'(addr[15:8]);
    c = int'(addr[7:0]);
    model_mem[int'(addr)] = val;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr <= 255 && c + dc >= 0 && c + dc <= 255) begin
          cen = (r + dr) * 256 + (c + dc);
`ifdef EVENT_SCHED3_DEDUP_EN
          if (!pend.exists(cen)) begin
            pend[cen] = 1'b1;
            exp_q.push_back(16'(cen));
          end
`else
          exp_q.push_back(16'(cen));
`endif
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for ready, then presents one event for exactly one cycle.
  task automatic applyStimulus(input logic [15:0] addr, input logic [DW-1:0] val);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!ready_for_new_event && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput($sformatf("ready for event 0x%04h", addr), 64'(ready_for_new_event), 64'd1);
    if (ready_for_new_event) begin
      in_event_addr  = addr;
      in_event_value = val;
      in_event_valid = 1'b1;
      @(negedge clk);
      in_event_valid = 1'b0;
      modelEvent(addr, val);
    end
  endtask

  // Raises window_req, collects windows and compares them with the model.
  // exp_lat > 0 also measures pop-to-valid latency on the first window.
  task automatic drainWindows(input string name, input int exp_n, input int exp_lat);
    int cycles;
    int lat;
    int n;
    got_q.delete();
    if (exp_lat > 0) begin
      cycles = 0;
      @(negedge clk);
      while (!ready_for_new_event && cycles < 50) begin
        @(negedge clk);
        cycles++;
      end
      window_req = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_window_valid && lat < 40);
      checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
    end
    window_req = 1'b1;
    cycles = 0;
    while (got_q.size() < exp_n && cycles < exp_n * 14 + 40) begin
      @(negedge clk);
      cycles++;
    end
    repeat (30) @(negedge clk);
    window_req = 1'b0;
    checkOutput({name, " window count"}, 64'(got_q.size()), 64'(exp_n));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s addr[%0d]", name, i), 64'(got_q[i].addr), 64'(exp_q[i]));
      checkOutput($sformatf("%s value[%0d]", name, i), 64'(got_q[i].value), 64'(modelWindow(exp_q[i])));
    end
    exp_q.delete();
    pend.delete();
  endtask

  task automatic spotCheck(input string name, input logic [15:0] centre, input int k, input logic [3:0] val);
    logic [63:0] actual;
    bit found;
    actual = 64'hDEAD;
    found = 1'b0;
    foreach (got_q[i]) begin
      if (!found && got_q[i].addr == centre) begin
        found = 1'b1;
        actual = 64'(got_q[i].value[k*DW +: DW]);
      end
    end
    checkOutput($sformatf("%s window 0x%04h k%0d", name, centre, k), actual, 64'(val));
  endtask

  initial begin
    int accepted;

    vecs[0] = '{16'h8080, 4'd5, 9, 16'h7F7F, 16'h8181, 16'h8080, 4, 4'd5, 16'h7F7F, 8, 4'd5};
    vecs[1] = '{16'h0000, 4'd3, 4, 16'h0000, 16'h0101, 16'h0101, 0, 4'd3, 16'h0000, 4, 4'd3};
    vecs[2] = '{16'hFFFF, 4'd7, 4, 16'hFEFE, 16'hFFFF, 16'hFFFF, 4, 4'd7, 16'hFEFE, 8, 4'd7};
    vecs[3] = '{16'h00FF, 4'd2, 4, 16'h00FE, 16'h01FF, 16'h00FE, 5, 4'd2, 16'h01FF, 1, 4'd2};
    vecs[4] = '{16'hFF00, 4'd9, 4, 16'hFE00, 16'hFF01, 16'hFF01, 3, 4'd9, 16'hFE00, 7, 4'd9};
    vecs[5] = '{16'h4000, 4'd1, 6, 16'h3F00, 16'h4101, 16'h3F00, 7, 4'd1, 16'h4101, 0, 4'd1};

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset ready", 64'(ready_for_new_event), 64'd1);
    checkOutput("reset valid", 64'(out_window_valid), 64'd0);
    checkOutput("reset value", 64'(out_window_value), 64'd0);
    checkOutput("reset addr", 64'(out_window_addr), 64'd0);

    // Single events: interior, corners and an edge.
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      applyStimulus(vecs[v].addr, vecs[v].val);
      drainWindows(nm, vecs[v].count, (v == 0) ? 11 : 0);
      if (got_q.size() > 0) begin
        checkOutput({nm, " first centre"}, 64'(got_q[0].addr), 64'(vecs[v].first));
        checkOutput({nm, " last centre"}, 64'(got_q[got_q.size()-1].addr), 64'(vecs[v].last));
      end
      spotCheck(nm, vecs[v].spot_a, vecs[v].spot_a_k, vecs[v].spot_a_val);
      spotCheck(nm, vecs[v].spot_b, vecs[v].spot_b_k, vecs[v].spot_b_val);
    end

    // Fill the FIFO: 28 interior events with disjoint windows give 252 entries.
    for (int i = 0; i < 28; i++) applyStimulus({8'h20, 8'(8'h10 + 3 * i)}, 4'((i % 15) + 1));
    repeat (12) @(negedge clk);
    checkOutput("fill ready low", 64'(ready_for_new_event), 64'd0);
    accepted = 0;
    in_event_addr  = 16'h5050;
    in_event_value = 4'd6;
    in_event_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ready_for_new_event) accepted++;
    end
    in_event_valid = 1'b0;
    checkOutput("fill extra event blocked", 64'(accepted), 64'd0);
    drainWindows("fill", 252, 0);
    @(negedge clk);
    checkOutput("fill ready after drain", 64'(ready_for_new_event), 64'd1);

    // Reset in the middle of a gather.
    applyStimulus(16'h3030, 4'd8);
    repeat (12) @(negedge clk);
    got_q.delete();
    window_req = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    window_req = 1'b0;
    @(negedge clk);
    checkOutput("mid-gather reset value", 64'(out_window_value), 64'd0);
    checkOutput("mid-gather reset addr", 64'(out_window_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    pend.delete();
    window_req = 1'b1;
    repeat (30) @(negedge clk);
    window_req = 1'b0;
    checkOutput("mid-gather no windows", 64'(got_q.size()), 64'd0);
    applyStimulus(16'h3131, 4'd2);
    drainWindows("after reset", 9, 11);
    spotCheck("after reset", 16'h3030, 4, 4'd8);
    spotCheck("after reset", 16'h3030, 8, 4'd2);

    // Two events at the same position before draining.
    applyStimulus(16'h8080, 4'd6);
    applyStimulus(16'h8080, 4'd4);
`ifdef EVENT_SCHED3_DEDUP_EN
    drainWindows("duplicate", 9, 0);
`else
    drainWindows("duplicate", 18, 0);
`endif
    spotCheck("duplicate", 16'h8080, 4, 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
